// File: rtl/meas_period_duty.sv
// meas_period_duty: averaged period and high-time of a synchronised waveform, on valid/ready
module meas_period_duty #(
  parameter int CNT_W       = 16,
  parameter int AVG_LOG2    = 2,
  parameter int SYNC_STAGES = 2
)(
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             ovf
);
  localparam int SW = CNT_W + AVG_LOG2;
  localparam int KW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
  localparam int N  = 1 << AVG_LOG2;
  typedef enum logic [1:0] {IDLE, ARM, MEAS, HOLD} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sync_q;
  logic s, prev, rise, fall, fell, last, sat, xfer, clr;
  logic [CNT_W-1:0] cnt, hlat, hs;
  logic [SW-1:0] psum, hsum, pnext, hnext;
  logic [KW-1:0] k;
  assign s = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev;
  assign fall = ~s & prev;
  // a period with no captured fall reports its full length as high time
  assign hs = fell ? hlat : cnt;
  assign last = k == KW'(N - 1);
  assign sat = state == MEAS && !rise && &cnt;
  assign xfer = out_valid && out_ready;
  assign clr = !en || state == IDLE || sat || (state == HOLD && xfer);
  assign pnext = psum + SW'(cnt);
  assign hnext = hsum + SW'(hs);
  always_comb begin
    state_nx = !en ? IDLE :
               state == IDLE ? ARM :
               state == ARM && rise ? MEAS :
               state == MEAS && sat ? ARM :
               state == MEAS && rise && last ? HOLD :
               state == HOLD && xfer ? ARM : state;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      prev <= 1'b0;
      cnt <= '0;
      hlat <= '0;
      fell <= 1'b0;
      psum <= '0;
      hsum <= '0;
      k <= '0;
      period <= '0;
      high_time <= '0;
      out_valid <= 1'b0;
      ovf <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in};
      prev <= s;
      if (state == ARM || state == MEAS) cnt <= rise ? CNT_W'(1) : cnt + 1'b1;
      if (rise) fell <= 1'b0;
      else if (fall && state == MEAS) begin
        fell <= 1'b1;
        hlat <= cnt;
      end
      if (!en) begin
        out_valid <= 1'b0;
        ovf <= 1'b0;
      end else begin
        if (xfer) out_valid <= 1'b0;
        if (sat) ovf <= 1'b1;
        if (state == MEAS && rise && last) begin
          out_valid <= 1'b1;
          period <= CNT_W'(pnext >> AVG_LOG2);
          high_time <= CNT_W'(hnext >> AVG_LOG2);
        end
      end
      if (clr) begin
        psum <= '0;
        hsum <= '0;
        k <= '0;
      end else if (state == MEAS && rise) begin
        psum <= pnext;
        hsum <= hnext;
        k <= k + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_meas_period_duty.sv
// tb_meas_period_duty: random and directed pulse trains checked against arithmetic means
module tb_meas_period_duty;
  localparam int CNT_W = 8;
  localparam int AVG_LOG2 = 2;
  localparam int N = 1 << AVG_LOG2;
  logic clk = 0, rstn = 0, en = 0, in = 0, out_ready = 0;
  logic out_valid, ovf;
  logic [CNT_W-1:0] period, high_time;
  int n_chk = 0, n_fail = 0;
  int pa[N], ha[N];
  int ep, eh;
  meas_period_duty #(.CNT_W(CNT_W), .AVG_LOG2(AVG_LOG2), .SYNC_STAGES(2)) dut (
    .clk(clk), .rstn(rstn), .en(en), .in(in), .out_ready(out_ready),
    .out_valid(out_valid), .period(period), .high_time(high_time), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic pulse(input int h, input int l);
    in = 1;
    repeat (h) @(negedge clk);
    in = 0;
    repeat (l) @(negedge clk);
  endtask
  // N sampled periods follow the arming rise; the (N+1)th rise completes the result
  task automatic gen_and_wait(input string tag);
    int ps, hsm, c;
    logic early;
    ps = 0;
    hsm = 0;
    early = 0;
    for (int i = 0; i < N; i++) begin
      in = 1;
      repeat (ha[i]) begin @(negedge clk); early |= out_valid; end
      in = 0;
      repeat (pa[i] - ha[i]) begin @(negedge clk); early |= out_valid; end
      ps += pa[i];
      hsm += ha[i];
    end
    ep = ps / N;
    eh = hsm / N;
    in = 1;
    c = 0;
    while (!out_valid && c < 300) begin @(negedge clk); c++; end
    chk({tag, "_early"}, 32'(early), 0);
    chk({tag, "_lat"}, c, 3);
    chk({tag, "_period"}, 32'(period), ep);
    chk({tag, "_high"}, 32'(high_time), eh);
  endtask
  task automatic run_meas(input string tag, input int hold);
    logic stable;
    out_ready = hold == 0;
    gen_and_wait(tag);
    if (hold > 0) begin
      stable = 1;
      repeat (hold) begin
        in = 1'($urandom_range(0, 1));
        @(negedge clk);
        stable &= out_valid && period == CNT_W'(ep) && high_time == CNT_W'(eh);
      end
      in = 0;
      repeat (4) begin
        @(negedge clk);
        stable &= out_valid && period == CNT_W'(ep) && high_time == CNT_W'(eh);
      end
      chk({tag, "_hold"}, 32'(stable), 1);
      out_ready = 1;
    end
    @(negedge clk);
    chk({tag, "_xfer"}, 32'(out_valid), 0);
    in = 0;
    out_ready = 0;
    repeat (6) @(negedge clk);
  endtask
  task automatic saturate(input string tag);
    logic v;
    out_ready = 1;
    pulse(10, 10);
    pulse(10, 300);
    v = out_valid;
    chk({tag, "_ovf"}, 32'(ovf), 1);
    chk({tag, "_novalid"}, 32'(v), 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_period", 32'(period), 0);
    chk("rst_high", 32'(high_time), 0);
    chk("rst_ovf", 32'(ovf), 0);
    rstn = 1;
    en = 1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < N; i++) begin pa[i] = 40; ha[i] = 10; end
    run_meas("t1", 0);
    for (int i = 0; i < N; i++) begin pa[i] = i % 2 ? 41 : 39; ha[i] = 20; end
    run_meas("t2", 0);
    for (int i = 0; i < N; i++) begin pa[i] = 25 + 3 * i; ha[i] = 4 + i; end
    run_meas("t3", 100);
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        pa[i] = $urandom_range(4, 120);
        ha[i] = $urandom_range(1, pa[i] - 1);
      end
      run_meas($sformatf("rnd%0d", r), r % 2 ? $urandom_range(1, 20) : 0);
    end
    saturate("t4");
    for (int i = 0; i < N; i++) begin pa[i] = 20; ha[i] = 7; end
    run_meas("t4m", 0);
    chk("t4_ovf_sticky", 32'(ovf), 1);
    for (int i = 0; i < N; i++) begin pa[i] = 30 + i; ha[i] = 12; end
    out_ready = 0;
    gen_and_wait("t5");
    chk("t5_ovf_before", 32'(ovf), 1);
    en = 0;
    @(negedge clk);
    chk("t5_valid_drop", 32'(out_valid), 0);
    chk("t5_ovf_clr", 32'(ovf), 0);
    chk("t5_period_kept", 32'(period), ep);
    chk("t5_high_kept", 32'(high_time), eh);
    in = 0;
    repeat (5) @(negedge clk);
    en = 1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < N; i++) begin pa[i] = 50; ha[i] = 25 + i; end
    run_meas("t5b", 0);
    saturate("t6");
    pulse(10, 10);
    in = 1;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rstn = 0;
    #1;
    chk("t6_valid", 32'(out_valid), 0);
    chk("t6_period", 32'(period), 0);
    chk("t6_high", 32'(high_time), 0);
    chk("t6_ovf", 32'(ovf), 0);
    @(negedge clk);
    in = 0;
    rstn = 1;
    repeat (6) @(negedge clk);
    for (int i = 0; i < N; i++) begin pa[i] = 60 - i; ha[i] = 3; end
    run_meas("t6b", 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
